// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file and writeback constants
package regfile_pkg;
  localparam int REG_AW  = 5;
  localparam int REG_DW  = 32;
  localparam int WB_NREQ = 3;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  localparam int WB_MEM    = 0;
  localparam int WB_ALU    = 1;
  localparam int WB_MULDIV = 2;

  localparam int CNT_W = 4;
  typedef logic [CNT_W-1:0] starve_cnt_t;
endpackage

// File: rtl/wb_prio_starve_arb.sv
// rtl/wb_prio_starve_arb.sv - fixed-priority one-hot pick with starvation override
module wb_prio_starve_arb #(
  parameter int NREQ = 3
) (
  input  logic            enable,
  input  logic [NREQ-1:0] valid,
  input  logic [NREQ-1:0] starved,
  output logic [NREQ-1:0] grant
);

  logic [NREQ-1:0] starved_valid;
  logic [NREQ-1:0] cand;
  logic            found;

  assign starved_valid = valid & starved;

  // Any starved requester preempts plain priority; ties go to the lowest index.
  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = (|starved_valid) ? starved_valid : valid;
    for (int i = 0; i < NREQ; i++) begin
      if (cand[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    if (!enable) grant = '0;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register-file write port among writeback units
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ         = WB_NREQ,
  parameter int AW           = REG_AW,
  parameter int DW           = REG_DW,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             wb_enable,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]  req_ready,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [DW-1:0]    wr_data,
  input  logic [AW-1:0]    rd_addr1,
  input  logic [AW-1:0]    rd_addr2,
  output logic             pend1,
  output logic             pend2
);

  localparam starve_cnt_t LIMIT = CNT_W'(STARVE_LIMIT);

  starve_cnt_t     cnt [NREQ];
  logic [NREQ-1:0] starved;
  logic            xfer;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  always_comb begin
    starved = '0;
    for (int i = 0; i < NREQ; i++) starved[i] = (cnt[i] == LIMIT);
  end

  wb_prio_starve_arb #(.NREQ(NREQ)) u_arb (
    .enable  (wb_enable),
    .valid   (req_valid),
    .starved (starved),
    .grant   (req_ready)
  );

  assign xfer = |(req_valid & req_ready);

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  // Writes to $zero are accepted from the requester but never reach the file.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else begin
      wr_en <= xfer && (sel_addr != '0);
      if (xfer) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || req_ready[i])
          cnt[i] <= '0;
        else if (cnt[i] != LIMIT)
          cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_addr[i*AW +: AW] == rd_addr1) pend1 = 1'b1;
      if (req_valid[i] && req_addr[i*AW +: AW] == rd_addr2) pend2 = 1'b1;
    end
    if (wr_en && wr_addr == rd_addr1) pend1 = 1'b1;
    if (wr_en && wr_addr == rd_addr2) pend2 = 1'b1;
    if (rd_addr1 == '0) pend1 = 1'b0;
    if (rd_addr2 == '0) pend2 = 1'b0;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic              CLK = 1'b0;
  logic              reset;
  logic              wb_enable;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [AW-1:0]     rd_addr1;
  logic [AW-1:0]     rd_addr2;
  logic              pend1;
  logic              pend2;

  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .STARVE_LIMIT(4)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .wb_enable (wb_enable),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .pend1     (pend1),
    .pend2     (pend2)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  compared   = 0;
  int  mismatched = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(logic [AW-1:0] a, logic [DW-1:0] d);
    exp_q.push_back('{addr: a, data: d});
  endtask

  task automatic set_req(int i, logic v, logic [AW-1:0] a, logic [DW-1:0] d);
    req_valid[i]         = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Write-port monitor: every register-file write must match the next expected entry.
  always @(negedge CLK) begin
    if (!reset && wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h expected no write", wr_addr, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_addr", 32'(wr_addr), 32'(mon_e.addr));
        chk("wb_data", wr_data, mon_e.data);
      end
    end
  end

  // Requester protocol: a stalled request must hold its address and data.
  logic [NREQ-1:0]    hold = '0;
  logic [NREQ*AW-1:0] p_addr;
  logic [NREQ*DW-1:0] p_data;
  always @(negedge CLK) begin
    if (reset) begin
      hold = '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (hold[i] && req_valid[i]) begin
          compared++;
          if (req_addr[i*AW +: AW] !== p_addr[i*AW +: AW] || req_data[i*DW +: DW] !== p_data[i*DW +: DW]) begin
            mismatched++;
            $display("FAIL protocol_stable req%0d: got addr %0d expected %0d", i,
                     req_addr[i*AW +: AW], p_addr[i*AW +: AW]);
          end
        end
      end
      hold   = req_valid & ~req_ready;
      p_addr = req_addr;
      p_data = req_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d0;
    reset = 1'b1; wb_enable = 1'b1;
    req_valid = '0; req_addr = '0; req_data = '0;
    rd_addr1 = '0; rd_addr2 = '0;
    cyc(); cyc();
    chk("reset_wr_en", 32'(wr_en), 0);
    chk("reset_wr_addr", 32'(wr_addr), 0);
    chk("reset_wr_data", wr_data, 0);
    chk("reset_ready", 32'(req_ready), 0);
    reset = 1'b0;
    cyc();

    // Priority
    set_req(WB_MEM, 1, 5'd3, 32'hAAAA_0001);
    set_req(WB_ALU, 1, 5'd4, 32'hBBBB_0002);
    set_req(WB_MULDIV, 1, 5'd5, 32'hCCCC_0003);
    settle();
    chk("prio_ready_all", 32'(req_ready), 32'b001);
    push(5'd3, 32'hAAAA_0001);
    cyc();
    chk("prio_wr_en", 32'(wr_en), 1);
    chk("prio_wr_addr", 32'(wr_addr), 3);
    set_req(WB_MEM, 0, 5'd3, 32'hAAAA_0001);
    settle();
    chk("prio_ready_drop0", 32'(req_ready), 32'b010);
    push(5'd4, 32'hBBBB_0002);
    cyc();
    chk("prio_wr_addr2", 32'(wr_addr), 4);
    set_req(WB_ALU, 0, 5'd4, 32'hBBBB_0002);
    settle();
    chk("prio_ready_req2", 32'(req_ready), 32'b100);
    push(5'd5, 32'hCCCC_0003);
    cyc();
    set_req(WB_MULDIV, 0, 5'd5, 32'hCCCC_0003);
    cyc();
    chk("idle_wr_en", 32'(wr_en), 0);

    // Asynchronous reset mid-write
    set_req(WB_ALU, 1, 5'd7, 32'hD00D_0007);
    cyc();
    set_req(WB_ALU, 0, 5'd7, 32'hD00D_0007);
    chk("midrst_pre_en", 32'(wr_en), 1);
    chk("midrst_pre_addr", 32'(wr_addr), 7);
    #2 reset = 1'b1;
    #1;
    chk("midrst_wr_en", 32'(wr_en), 0);
    chk("midrst_wr_addr", 32'(wr_addr), 0);
    chk("midrst_wr_data", wr_data, 0);
    cyc();
    reset = 1'b0;
    cyc();

    // Starvation: requester 2 wins after four losses
    d0 = 32'h0000_0100;
    set_req(WB_MULDIV, 1, 5'd9, 32'h0000_0099);
    for (int k = 0; k < 4; k++) begin
      set_req(WB_MEM, 1, 5'd1, d0);
      settle();
      chk("starve_lose", 32'(req_ready), 32'b001);
      push(5'd1, d0);
      cyc();
      d0 = d0 + 1;
    end
    d0 = d0 - 1;
    settle();
    chk("starve_grant", 32'(req_ready), 32'b100);
    push(5'd9, 32'h0000_0099);
    cyc();
    chk("starve_wr_addr", 32'(wr_addr), 9);
    set_req(WB_MULDIV, 1, 5'd10, 32'h0000_00AA);
    for (int k = 0; k < 4; k++) begin
      set_req(WB_MEM, 1, 5'd1, d0);
      settle();
      chk("starve_cnt_cleared", 32'(req_ready), 32'b001);
      push(5'd1, d0);
      cyc();
      d0 = d0 + 1;
    end
    settle();
    chk("starve_regrant", 32'(req_ready), 32'b100);
    push(5'd10, 32'h0000_00AA);
    cyc();
    req_valid = '0;
    cyc();

    // Zero address and zero data
    set_req(WB_MEM, 1, 5'd0, 32'h0000_DEAD);
    settle();
    chk("zero_addr_ready", 32'(req_ready), 32'b001);
    cyc();
    chk("zero_addr_wr_en", 32'(wr_en), 0);
    set_req(WB_MEM, 1, 5'd6, 32'h0);
    settle();
    chk("zero_data_ready", 32'(req_ready), 32'b001);
    push(5'd6, 32'h0);
    cyc();
    chk("zero_data_wr_en", 32'(wr_en), 1);
    chk("zero_data_wr_addr", 32'(wr_addr), 6);
    chk("zero_data_wr_data", wr_data, 0);
    req_valid = '0;
    cyc();

    // Pending flags
    rd_addr1 = 5'd12; rd_addr2 = 5'd13;
    set_req(WB_ALU, 1, 5'd12, 32'h1212_1212);
    settle();
    chk("pend1_request", 32'(pend1), 1);
    chk("pend2_other", 32'(pend2), 0);
    push(5'd12, 32'h1212_1212);
    cyc();
    set_req(WB_ALU, 0, 5'd12, 32'h1212_1212);
    settle();
    chk("pend1_inflight_addr", 32'(wr_addr), 12);
    chk("pend1_inflight", 32'(pend1), 1);
    cyc();
    chk("pend1_idle", 32'(pend1), 0);
    rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    set_req(WB_MEM, 1, 5'd0, 32'h5);
    settle();
    chk("pend2_zero", 32'(pend2), 0);
    chk("pend1_zero", 32'(pend1), 0);
    cyc();
    req_valid = '0;
    cyc();

    // Global disable; requester 1 saturates and then beats requester 0
    wb_enable = 1'b0;
    set_req(WB_ALU, 1, 5'd20, 32'h0000_000E);
    for (int k = 0; k < 6; k++) begin
      settle();
      chk("disabled_ready", 32'(req_ready), 0);
      cyc();
      chk("disabled_wr_en", 32'(wr_en), 0);
    end
    wb_enable = 1'b1;
    set_req(WB_MEM, 1, 5'd21, 32'h0000_000F);
    settle();
    chk("reenable_starved_wins", 32'(req_ready), 32'b010);
    push(5'd20, 32'h0000_000E);
    cyc();
    set_req(WB_ALU, 0, 5'd20, 32'h0000_000E);
    settle();
    chk("reenable_then_mem", 32'(req_ready), 32'b001);
    push(5'd21, 32'h0000_000F);
    cyc();
    req_valid = '0;
    cyc();
    cyc();

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port among NREQ writeback requesters: ALU, load unit and mult/div unit.
- Fixed-priority arbitration with a starvation override. The winning request is registered and driven to the register-file write port.
- Also provides combinational pending-write flags so decode can stall on RAW hazards.
- Sits between the writeback sources and the 32x32 register file.

Parameters:
- NREQ, 3, number of writeback requesters; index 0 has the highest priority.
- AW, 5, register address width.
- DW, 32, data width.
- STARVE_LIMIT, 4, wait cycles before a requester is forced to win; legal range 1..15.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- wb_enable  in  1  global grant enable; when 0, nothing is accepted.
- req_valid  in  NREQ  per-requester write request.
- req_addr  in  NREQ*AW  packed destination registers; requester i uses bits [i*AW +: AW].
- req_data  in  NREQ*DW  packed write data; requester i uses bits [i*DW +: DW].
- req_ready  out  NREQ  one-hot grant; a transfer happens when req_valid[i] and req_ready[i] are both 1.
- wr_en  out  1  register-file write enable (registered).
- wr_addr  out  AW  register-file write address (registered).
- wr_data  out  DW  register-file write data (registered).
- rd_addr1  in  AW  decode source address 1.
- rd_addr2  in  AW  decode source address 2.
- pend1  out  1  a write to rd_addr1 is in flight.
- pend2  out  1  a write to rd_addr2 is in flight.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - wr_en=0, wr_addr=0, wr_data=0.
  - All starvation counters = 0.
  - req_ready follows its combinational equation with counters at 0.
- Grant (combinational):
  - If wb_enable=0, req_ready=0.
  - Otherwise, if any valid requester has cnt==STARVE_LIMIT, the lowest-index such requester wins.
  - Otherwise the lowest-index valid requester wins.
  - req_ready is never asserted for a requester with req_valid=0; at most one bit is set.
- Write latency: the accepted request appears on wr_en/wr_addr/wr_data on the next rising edge, one cycle after the transfer.
- Output registers:
  - With no transfer, wr_en=0; wr_addr and wr_data hold their previous values.
  - A transfer to address 0 is accepted (ready=1) but wr_en=0, so $zero is never written.
  - Data value 0 is written normally; zero data is NOT suppressed.
- Starvation counter, per requester, 4 bits:
  - Increments when req_valid=1 and the requester is not granted, saturating at STARVE_LIMIT. This also happens while wb_enable=0.
  - Clears to 0 on a transfer or when req_valid=0.
- Same destination from several requesters in one cycle: only the winner transfers. The losers keep req_valid and are written in later cycles in grant order. Program ordering is the issuing units' responsibility.
- Pending flags:
  - pend1 = (rd_addr1 != 0) and ((any i with req_valid[i] and req_addr[i]==rd_addr1) or (wr_en and wr_addr==rd_addr1)).
  - pend2 is the same for rd_addr2.
  - Both are purely combinational; they are 0 whenever the source address is 0.
- Requester protocol (bench asserts):
  - A requester holding req_valid=1 without ready must keep addr and data stable.
  - Dropping req_valid without a transfer is permitted and clears that requester's counter.

Decomposition:
- Shared package regfile_pkg:
  - REG_AW=5, REG_DW=32, REG_ZERO=5'd0, WB_NREQ=3.
  - Requester index constants WB_MEM=0, WB_ALU=1, WB_MULDIV=2.
- One natural sub-module: wb_prio_starve_arb. It takes the valid vector and starvation flags, and produces the one-hot grant (the combinational priority pick with starvation override).
- Counters, output registers and pending logic stay in the top level.

Test Plan:
- Reset mid-write: with wr_en=1 and wr_addr=7, assert reset asynchronously between edges -> wr_en, wr_addr and wr_data go to 0 immediately, without waiting for a clock edge.
- Priority: req_valid=3'b111 with addrs 3/4/5 and data A/B/C -> req_ready=001; next cycle wr_en=1, wr_addr=3, wr_data=A. Drop requester 0 -> requester 1 (addr 4) wins next.
- Starvation, STARVE_LIMIT=4: requester 0 is valid continuously with new data each cycle and requester 2 (addr 9) is held valid -> requester 2 is granted on the 5th cycle, after 4 losses; wr_addr=9 one cycle later; its counter returns to 0.
- Zero handling:
  - addr=0, data=0xDEAD -> ready=1 and wr_en stays 0.
  - addr=6, data=0 -> wr_en=1, wr_addr=6, wr_data=0.
- Pending flags:
  - req_valid[1]=1 with addr 12, rd_addr1=12 -> pend1=1.
  - Cycle after the transfer (wr_addr=12) -> pend1=1.
  - Following idle cycle -> pend1=0.
  - rd_addr2=0 with a request to addr 0 -> pend2=0.
- wb_enable=0 for 6 cycles with requester 1 valid -> req_ready=0 and wr_en=0 throughout; the counter saturates at 4. Re-enable -> requester 1 wins even though requester 0 is also valid.
